mult_shift_add: RTL and testbench

//  Parametrised sequential WIDTH x WIDTH multiplier, add-shift algorithm, one multiplier bit per clock.

---
 rtl/mult_pkg.sv | 12 +
 rtl/add_sub_n.sv | 26 ++
 rtl/mult_shift_add.sv | 104 ++++++++++
 tb/tb_mult_shift_add.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential add-shift multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  localparam int MAX_WIDTH = 32;

endpackage : mult_pkg

// File: rtl/add_sub_n.sv
// WIDTH-bit adder/subtractor producing a WIDTH+1 bit result.
// Operands are sign- or zero-extended by one bit so that the top bit of S is
// the true sign (signed) or the carry out (unsigned).
module add_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             fn,    // 1 = A - B
  input  logic             sext,  // 1 = sign-extend operands
  output logic [WIDTH:0]   S
);

  logic [WIDTH:0] w_a;
  logic [WIDTH:0] w_b;
  logic [WIDTH:0] w_b_op;

  // Extend operands, then subtract as A + ~B + 1.
  always_comb begin
    w_a    = {sext & A[WIDTH-1], A};
    w_b    = {sext & B[WIDTH-1], B};
    w_b_op = fn ? ~w_b : w_b;
    S      = w_a + w_b_op + {{WIDTH{1'b0}}, fn};
  end

endmodule : add_sub_n

// File: rtl/mult_shift_add.sv
// Sequential WIDTH x WIDTH multiplier, one multiplier bit per clock.
// Signed mode adds the multiplicand for every set bit except the last, which
// carries negative weight in two's complement and is therefore subtracted.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mult_shift_add: WIDTH out of range");
  end

  mult_state_e       r_state;
  mult_state_e       w_next_state;
  logic              r_x;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_s;
  logic              r_mode;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_last;
  logic              w_fn;
  logic [WIDTH:0]    w_addsub;
  logic [WIDTH:0]    w_sum;

  add_sub_n #(.WIDTH(WIDTH)) u_add_sub (
    .A    (r_a),
    .B    (r_s),
    .fn   (w_fn),
    .sext (r_mode),
    .S    (w_addsub)
  );

  // Next state and partial-product selection for the current iteration.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = (r_cnt == CNT_W'(WIDTH - 1));
    w_fn         = r_mode & w_last;
    // A zero multiplier bit passes the accumulator through unchanged; X keeps
    // the sign so the arithmetic shift stays correct.
    w_sum        = r_b[0] ? w_addsub : {r_x, r_a};
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (w_last) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, counter and datapath registers; start during RUN is not sampled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_x     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_x    <= 1'b0;
        r_a    <= '0;
        r_b    <= multiplier;
        r_s    <= multiplicand;
        r_mode <= signed_mode;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_a   <= w_sum[WIDTH:1];
        r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
        r_x   <= r_mode & w_sum[WIDTH];
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ready   = (r_state != RUN);
  assign done    = (r_state == DONE);
  assign product = {r_a, r_b};

endmodule : mult_shift_add

// File: tb/tb_mult_shift_add.sv
// Randomised and directed bench for mult_shift_add at WIDTH 8, 4 and 16,
// checked against a plain-arithmetic multiply model.
module tb_mult_shift_add;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // WIDTH = 8 instance
  logic        s8_start = 0, s8_sm = 0, s8_ready, s8_done;
  logic [7:0]  s8_a = 0, s8_b = 0;
  logic [15:0] s8_product;
  mult_shift_add #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .start(s8_start), .signed_mode(s8_sm),
    .multiplicand(s8_a), .multiplier(s8_b),
    .ready(s8_ready), .done(s8_done), .product(s8_product));

  // WIDTH = 4 instance
  logic        s4_start = 0, s4_sm = 0, s4_ready, s4_done;
  logic [3:0]  s4_a = 0, s4_b = 0;
  logic [7:0]  s4_product;
  mult_shift_add #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .start(s4_start), .signed_mode(s4_sm),
    .multiplicand(s4_a), .multiplier(s4_b),
    .ready(s4_ready), .done(s4_done), .product(s4_product));

  // WIDTH = 16 instance
  logic        s16_start = 0, s16_sm = 0, s16_ready, s16_done;
  logic [15:0] s16_a = 0, s16_b = 0;
  logic [31:0] s16_product;
  mult_shift_add #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset_n(rst_n), .start(s16_start), .signed_mode(s16_sm),
    .multiplicand(s16_a), .multiplier(s16_b),
    .ready(s16_ready), .done(s16_done), .product(s16_product));

  // Reference: true integer product, truncated to 2*w bits.
  function automatic longint unsigned ref_mul(input int w, input bit sm,
                                              input longint unsigned a,
                                              input longint unsigned b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return longint'(p) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    s8_sm = sm; s8_a = a; s8_b = b; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom); s8_sm = 1'($urandom);
    lat = 0;
    while (s8_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    p = s8_product;
  endtask

  task automatic run4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p, output int lat);
    s4_sm = sm; s4_a = a; s4_b = b; s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0; s4_a = 4'($urandom); s4_b = 4'($urandom);
    lat = 0;
    while (s4_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    p = s4_product;
  endtask

  task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat, output int bad_rdy);
    s16_sm = sm; s16_a = a; s16_b = b; s16_start = 1'b1;
    @(posedge clk); #1;
    s16_start = 1'b0; s16_a = 16'($urandom); s16_b = 16'($urandom);
    lat = 0; bad_rdy = 0;
    while (s16_done !== 1'b1 && lat < 60) begin
      if (s16_ready !== 1'b0) bad_rdy++;
      @(posedge clk); #1; lat++;
    end
    p = s16_product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s8_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", s8_ready); else passed++;
    checks++; if (s8_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", s8_done); else passed++;
    checks++; if (s8_product !== 16'h0) $display("FAIL reset_product got=%h exp=0000", s8_product); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s8_done !== 1'b0 || s8_ready !== 1'b1)
      $display("FAIL idle_after_reset got done=%b ready=%b exp done=0 ready=1", s8_done, s8_ready);
    else passed++;
  endtask

  task automatic test_directed();
    logic [15:0] p; int lat;
    run8(1'b1, 8'd7, 8'hFD, p, lat);
    checks++; if (p !== 16'hFFEB) $display("FAIL s_7x-3 got=%h exp=ffeb", p); else passed++;
    checks++; if (lat !== 8) $display("FAIL latency_w8 got=%0d exp=8", lat); else passed++;
    run8(1'b1, 8'h80, 8'h80, p, lat);
    checks++; if (p !== 16'h4000) $display("FAIL s_min_x_min got=%h exp=4000", p); else passed++;
    run8(1'b1, 8'h80, 8'h7F, p, lat);
    checks++; if (p !== 16'hC080) $display("FAIL s_min_x_max got=%h exp=c080", p); else passed++;
    run8(1'b0, 8'hFF, 8'hFF, p, lat);
    checks++; if (p !== 16'hFE01) $display("FAIL u_full_scale got=%h exp=fe01", p); else passed++;
    run8(1'b0, 8'd0, 8'd200, p, lat);
    checks++; if (p !== 16'h0000) $display("FAIL u_zero got=%h exp=0000", p); else passed++;
    run8(1'b1, 8'hB3, 8'd0, p, lat);
    checks++; if (p !== 16'h0000) $display("FAIL s_zero got=%h exp=0000", p); else passed++;
    // DONE holds its result with start low
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s8_done !== 1'b1 || s8_product !== 16'h0000)
      $display("FAIL done_hold got done=%b p=%h exp done=1 p=0000", s8_done, s8_product);
    else passed++;
  endtask

  task automatic test_random8();
    logic [15:0] p, e; int lat;
    logic [7:0] a, b; logic sm;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      e = 16'(ref_mul(8, sm, a, b));
      run8(sm, a, b, p, lat);
      checks++; if (p !== e || lat !== 8)
        $display("FAIL rand8 sm=%b a=%h b=%h got=%h lat=%0d exp=%h lat=8", sm, a, b, p, lat, e);
      else passed++;
    end
  endtask

  task automatic test_start_in_run();
    logic [15:0] e; int lat;
    e = 16'(ref_mul(8, 1'b1, 8'd100, 8'hC5));
    s8_sm = 1'b1; s8_a = 8'd100; s8_b = 8'hC5; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // pulse start with different operands in the third RUN cycle
    s8_sm = 1'b0; s8_a = 8'hFF; s8_b = 8'hFF; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    lat = 3;
    while (s8_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (s8_product !== e || lat !== 8)
      $display("FAIL start_in_run got=%h lat=%0d exp=%h lat=8", s8_product, lat, e);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] p, e; int lat;
    run8(1'b0, 8'd13, 8'd17, p, lat);
    checks++; if (p !== 16'd221) $display("FAIL b2b_first got=%h exp=00dd", p); else passed++;
    checks++; if (s8_ready !== 1'b1) $display("FAIL ready_in_done got=%b exp=1", s8_ready); else passed++;
    e = 16'(ref_mul(8, 1'b1, 8'hF6, 8'd9));
    s8_sm = 1'b1; s8_a = 8'hF6; s8_b = 8'd9; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    checks++; if (s8_done !== 1'b0 || s8_ready !== 1'b0)
      $display("FAIL b2b_done_drop got done=%b ready=%b exp 0 0", s8_done, s8_ready);
    else passed++;
    lat = 0;
    while (s8_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (s8_product !== e || lat !== 8)
      $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=8", s8_product, lat, e);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; int lat;
    s8_sm = 1'b0; s8_a = 8'hAB; s8_b = 8'hCD; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if (s8_ready !== 1'b1 || s8_done !== 1'b0 || s8_product !== 16'h0)
      $display("FAIL mid_run_reset got ready=%b done=%b p=%h exp 1 0 0000", s8_ready, s8_done, s8_product);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s8_done !== 1'b0 || s8_product !== 16'h0)
      $display("FAIL after_reset_idle got done=%b p=%h exp 0 0000", s8_done, s8_product);
    else passed++;
    run8(1'b0, 8'd5, 8'd5, p, lat);
    checks++; if (p !== 16'h0019 || lat !== 8)
      $display("FAIL post_reset_5x5 got=%h lat=%0d exp=0019 lat=8", p, lat);
    else passed++;
  endtask

  task automatic test_exhaustive4();
    logic [7:0] p, e; int lat;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          e = 8'(ref_mul(4, 1'(m), longint'(a), longint'(b)));
          run4(1'(m), 4'(a), 4'(b), p, lat);
          checks++; if (p !== e || lat !== 4)
            $display("FAIL exh4 sm=%0d a=%0d b=%0d got=%h lat=%0d exp=%h lat=4", m, a, b, p, lat, e);
          else passed++;
        end
  endtask

  task automatic test_random16();
    logic [31:0] p, e; int lat, bad;
    logic [15:0] a, b; logic sm;
    for (int i = 0; i < 400; i++) begin
      case (i)
        0: begin a = 16'h8000; b = 16'h8000; sm = 1'b1; end
        1: begin a = 16'hFFFF; b = 16'hFFFF; sm = 1'b0; end
        default: begin a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom); end
      endcase
      e = 32'(ref_mul(16, sm, a, b));
      run16(sm, a, b, p, lat, bad);
      checks++; if (p !== e || lat !== 16 || bad !== 0)
        $display("FAIL rand16 sm=%b a=%h b=%h got=%h lat=%0d rdy_err=%0d exp=%h lat=16", sm, a, b, p, lat, bad, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive4();
    test_random16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_mult_shift_add
